// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, branch-flush, fetch-miss and data-memory-wait control for a 5-stage pipeline.
// Optional macro PIPE_CTRL_STATS_EN adds saturating stall/flush statistics counters.
`default_nettype none

module pipeline_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       IDEX_MemRead_i,
   input  logic [4:0] IDEX_Rt_i,
   input  logic [4:0] IFID_Rs_i,
   input  logic [4:0] IFID_Rt_i,
   input  logic       Branch_i,
   input  logic       imem_ready_i,
   input  logic       dmem_busy_i,
   output logic       PCWrite_o,
   output logic       WriteIFID_o,
   output logic       Flush_o,
   output logic       Bubble_o,
   output logic       Stall_o,
   output logic       err_o,
   output logic [1:0] state_o
`ifdef PIPE_CTRL_STATS_EN
   ,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERROR   = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       hazard;

   assign hazard = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                   ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

   assign state_o = state;

   // Reset forces every control output low, independent of the clock.
   always_comb begin
      PCWrite_o   = 1'b0;
      WriteIFID_o = 1'b0;
      Flush_o     = 1'b0;
      Bubble_o    = 1'b0;
      Stall_o     = 1'b0;
      if (!rst_i) begin
         PCWrite_o = 1'b0;
      end else if (state == ERROR) begin
         Stall_o = 1'b1;
      end else if (dmem_busy_i) begin
         Stall_o = 1'b1;
      end else if (hazard) begin
         Bubble_o = 1'b1;
      end else if (Branch_i) begin
         PCWrite_o   = 1'b1;
         WriteIFID_o = 1'b1;
         Flush_o     = 1'b1;
      end else if (!imem_ready_i) begin
         WriteIFID_o = 1'b1;
         Flush_o     = 1'b1;
      end else begin
         PCWrite_o   = 1'b1;
         WriteIFID_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         err_o    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (dmem_busy_i) begin
                  state    <= MEMWAIT;
                  wait_cnt <= 8'd1;
               end
            end
            MEMWAIT: begin
               if (!dmem_busy_i) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt >= TIMEOUT_LAST) begin
                  // This busy cycle brings the count to TIMEOUT.
                  state    <= ERROR;
                  wait_cnt <= wait_cnt + 8'd1;
                  err_o    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ERROR: begin
               err_o <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_STATS_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= 16'd0;
         flush_cnt_o <= 16'd0;
      end else begin
         if (!PCWrite_o && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
         end
         if (Flush_o && (flush_cnt_o != 16'hFFFF)) begin
            flush_cnt_o <= flush_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl; a second instance with TIMEOUT=4 covers the timeout path.
`default_nettype none

module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       idex_memread = 1'b0;
   logic [4:0] idex_rt = 5'd0;
   logic [4:0] ifid_rs = 5'd0;
   logic [4:0] ifid_rt = 5'd0;
   logic       branch = 1'b0;
   logic       imem_ready = 1'b1;
   logic       dmem_busy = 1'b0;
   logic       dmem_busy_t = 1'b0;

   logic       pcw, wif, flush, bubble, stall, err;
   logic [1:0] state;
   logic       pcw_t, wif_t, flush_t, bubble_t, stall_t, err_t;
   logic [1:0] state_t;
   logic [4:0] outs, outs_t;

   int checks = 0;
   int failures = 0;

`ifdef PIPE_CTRL_STATS_EN
   logic [15:0] stall_cnt, flush_cnt, stall_cnt_t, flush_cnt_t;
`endif

   assign outs   = {pcw, wif, flush, bubble, stall};
   assign outs_t = {pcw_t, wif_t, flush_t, bubble_t, stall_t};

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk_i(clk), .rst_i(rst_n),
      .IDEX_MemRead_i(idex_memread), .IDEX_Rt_i(idex_rt),
      .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt),
      .Branch_i(branch), .imem_ready_i(imem_ready), .dmem_busy_i(dmem_busy),
      .PCWrite_o(pcw), .WriteIFID_o(wif), .Flush_o(flush), .Bubble_o(bubble),
      .Stall_o(stall), .err_o(err), .state_o(state)
`ifdef PIPE_CTRL_STATS_EN
      , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
   );

   pipeline_ctrl #(.TIMEOUT(4)) dut_to (
      .clk_i(clk), .rst_i(rst_n),
      .IDEX_MemRead_i(idex_memread), .IDEX_Rt_i(idex_rt),
      .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt),
      .Branch_i(branch), .imem_ready_i(imem_ready), .dmem_busy_i(dmem_busy_t),
      .PCWrite_o(pcw_t), .WriteIFID_o(wif_t), .Flush_o(flush_t), .Bubble_o(bubble_t),
      .Stall_o(stall_t), .err_o(err_t), .state_o(state_t)
`ifdef PIPE_CTRL_STATS_EN
      , .stall_cnt_o(stall_cnt_t), .flush_cnt_o(flush_cnt_t)
`endif
   );

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      idex_memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      branch = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0; dmem_busy_t = 1'b0;
   endtask

   // Outputs are ordered {PCWrite, WriteIFID, Flush, Bubble, Stall}.
   task automatic step_chk(input string tag, input logic [4:0] exp);
      @(negedge clk);
      check(tag, 16'(outs), 16'(exp));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("reset_outs", 16'(outs), 16'h0);
      check("reset_state", 16'(state), 16'h0);
      check("reset_err", 16'(err), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      idle();
      step_chk("normal", 5'b11000);

      idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
      step_chk("load_use", 5'b00010);
      idle();
      step_chk("load_use_next", 5'b11000);

      idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
      step_chk("rt0_exclusion", 5'b11000);

      idex_memread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; branch = 1'b1;
      step_chk("branch_hazard", 5'b00010);
      idex_memread = 1'b0;
      step_chk("branch_nohazard", 5'b11100);

      idle(); imem_ready = 1'b0;
      step_chk("fetch_miss", 5'b01100);
      branch = 1'b1;
      step_chk("branch_and_miss", 5'b11100);

      idle(); dmem_busy = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         if (c == 3) begin
            branch = 1'b1; idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
         end
         @(negedge clk);
         check($sformatf("memwait_stall_c%0d", c), 16'(outs), 16'(5'b00001));
         check($sformatf("memwait_state_c%0d", c), 16'(state), (c == 1) ? 16'h0 : 16'h1);
         tick();
      end
      idle(); branch = 1'b1;
      @(negedge clk);
      check("memwait_release_outs", 16'(outs), 16'(5'b11100));
      tick();
      idle();
      @(negedge clk);
      check("memwait_release_state", 16'(state), 16'h0);
      check("memwait_release_err", 16'(err), 16'h0);
      tick();

      // Busy drops in the cycle that would have reached TIMEOUT.
      dmem_busy_t = 1'b1;
      tick(); tick(); tick();
      dmem_busy_t = 1'b0;
      tick();
      check("timeout_drop_state", 16'(state_t), 16'h0);
      check("timeout_drop_err", 16'(err_t), 16'h0);

      dmem_busy_t = 1'b1;
      tick(); tick(); tick();
      check("timeout_pre_state", 16'(state_t), 16'h1);
      check("timeout_pre_err", 16'(err_t), 16'h0);
      tick();
      check("timeout_state", 16'(state_t), 16'h2);
      check("timeout_err", 16'(err_t), 16'h1);
      dmem_busy_t = 1'b0;
      @(negedge clk);
      check("error_outs", 16'(outs_t), 16'(5'b00001));
      tick();
      check("error_sticky_state", 16'(state_t), 16'h2);
      check("error_sticky_err", 16'(err_t), 16'h1);
      check("other_inst_state", 16'(state), 16'h0);

      rst_n = 1'b0;
      #2;
      check("rst_pulse_state", 16'(state_t), 16'h0);
      check("rst_pulse_err", 16'(err_t), 16'h0);
      check("rst_pulse_outs", 16'(outs), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("after_reset_outs", 16'(outs_t), 16'(5'b11000));
      tick();

`ifdef PIPE_CTRL_STATS_EN
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick(); tick(); tick();
      branch = 1'b1;
      tick();
      idle();
      check("stats_stall_cnt", stall_cnt, 16'd3);
      check("stats_flush_cnt", flush_cnt, 16'd4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, number of consecutive data-memory busy cycles that forces the ERROR state (legal range 2..255).
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 IDEX_MemRead_i  in  1  the instruction in EX is a load.
REQ-005 IDEX_Rt_i  in  5  destination register of the instruction in EX.
REQ-006 IFID_Rs_i / IFID_Rt_i  in  5 each  source registers of the instruction in ID.
REQ-007 Branch_i  in  1  taken branch or jump resolved in ID this cycle.
REQ-008 imem_ready_i  in  1  instruction fetch data valid this cycle.
REQ-009 dmem_busy_i  in  1  data memory requests a pipeline freeze this cycle.
REQ-010 PCWrite_o  out  1  PC update enable.
REQ-011 WriteIFID_o  out  1  IF/ID write enable.
REQ-012 Flush_o  out  1  IF/ID flush (loads zero, i.e. nop).
REQ-013 Bubble_o  out  1  force control fields into ID/EX to zero.
REQ-014 Stall_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-015 err_o  out  1  sticky data-memory timeout flag.
REQ-016 state_o  out  2  current FSM state: RUN=0, MEMWAIT=1, ERROR=2; the value 3 is unused.

Function
REQ-017 Define the load-use hazard H as: IDEX_MemRead_i=1, IDEX_Rt_i!=0, and IDEX_Rt_i equals IFID_Rs_i or IFID_Rt_i.
REQ-018 All outputs except err_o and state_o are combinational from the state and the current inputs; the priority order is: ERROR, then dmem_busy_i, then H, then Branch_i, then !imem_ready_i, then normal.
REQ-019 RUN, normal: PCWrite=1, WriteIFID=1, Flush=0, Bubble=0, Stall=0.
REQ-020 RUN with dmem_busy_i=1: Stall=1, PCWrite=0, WriteIFID=0, Flush=0, Bubble=0; next state MEMWAIT with wait_cnt=1.
REQ-021 RUN with H: PCWrite=0, WriteIFID=0, Bubble=1, Flush=0; a simultaneous Branch_i is suppressed because the branch depends on the load; the stall lasts exactly one cycle.
REQ-022 RUN with Branch_i and no H: PCWrite=1, WriteIFID=1, Flush=1.
REQ-023 RUN with !imem_ready_i and no Branch_i: PCWrite=0, WriteIFID=1, Flush=1 (nop enters ID, PC holds).
REQ-024 When Branch_i and !imem_ready_i coincide, the branch redirect wins: PCWrite=1, Flush=1.
REQ-025 MEMWAIT while dmem_busy_i=1: outputs as in REQ-020; Branch_i, H and imem_ready_i are ignored; wait_cnt increments each cycle.
REQ-026 MEMWAIT when dmem_busy_i is sampled 0: outputs follow the RUN rules in the same cycle; next state RUN; wait_cnt clears to 0.
REQ-027 When wait_cnt reaches TIMEOUT while dmem_busy_i=1, the next state is ERROR; dmem_busy_i falling in that same cycle takes precedence and the next state is RUN.
REQ-028 ERROR: err_o=1; PCWrite=0, WriteIFID=0, Stall=1, Flush=0, Bubble=0; ERROR is left only by reset.
REQ-029 wait_cnt is 8 bits and never wraps, because it is bounded by TIMEOUT.

Reset
REQ-030 While rst_i=0, independent of the clock: state=RUN, wait_cnt=0, err_o=0, PCWrite=0, WriteIFID=0, Flush=0, Bubble=0, Stall=0, and any statistics counters are 0.
REQ-031 Reset asserted during MEMWAIT or ERROR returns the block to RUN immediately; normal outputs resume on the first cycle after rst_i rises.

Configuration
REQ-032 Macro PIPE_CTRL_STATS_EN: when defined, add the outputs stall_cnt_o[15:0] (cycles with PCWrite_o=0 outside reset) and flush_cnt_o[15:0] (cycles with Flush_o=1); both saturate at 16'hFFFF and reset to 0.
REQ-033 When PIPE_CTRL_STATS_EN is undefined, these ports and their counters are absent and all other behaviour is identical.

Verification
REQ-034 Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> PCWrite=0, WriteIFID=0, Bubble=1 in that cycle; RUN outputs on the next cycle.
REQ-035 Rt=0 exclusion: IDEX_MemRead=1, IDEX_Rt=0, IFID_Rs=0 -> PCWrite=1, Bubble=0.
REQ-036 Branch with hazard: Branch_i=1 and H true in the same cycle -> Flush=0, Bubble=1; with H false -> Flush=1, PCWrite=1.
REQ-037 Memory wait: dmem_busy_i=1 for 5 cycles -> state_o=1 from cycle 2 to cycle 5, Stall=1 for all 5 cycles; dmem_busy_i=0 -> state_o=0 next edge and err_o=0.
REQ-038 Timeout: TIMEOUT=4 and dmem_busy_i held at 1 -> state_o=2 and err_o=1 after the 4th busy edge; dropping dmem_busy_i keeps the ERROR state; pulsing rst_i low -> state_o=0 and err_o=0.
REQ-039 Statistics (PIPE_CTRL_STATS_EN): 3 fetch-miss cycles followed by 1 branch -> stall_cnt_o=3, flush_cnt_o=4.
